// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the CPU pipeline.
//
// Takes the execute-stage ALU result as the effective address and performs
// byte, halfword and word loads and stores over a request/acknowledge bus.
// It holds the pipeline (stall) while an access is in flight. It returns the
// aligned, sign- or zero-extended load data to write-back on mem_data.
//
// Ports:
//   clk, rst_n      stage clock (rising edge), asynchronous active-low reset
//   mem_read        current instruction is a load
//   mem_write       current instruction is a store
//   size            00 byte, 01 half, 10/11 word
//   load_unsigned   zero-extend the load result (otherwise sign-extend)
//   alu_result      effective address
//   store_data      right-aligned store value
//   stall           holds PC and upstream stages while high
//   mem_data        load result (0 on a misaligned access or a timeout)
//   misalign        misaligned access detected (combinational)
//   bus_err         one-cycle pulse in DONE when the access timed out
//   bus_req/we/addr/be/wdata   registered bus request fields
//   bus_ack, bus_rdata         slave completion and read data
//
// TIMEOUT (1..255) is the number of BUSY cycles without bus_ack after which
// the access is abandoned.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] mem_data,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // The counter holds the number of BUSY cycles already completed without
    // an ack, so the access is abandoned while it reads TIMEOUT-1.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        access, misalign_c;
    logic        start, ack_hit, timeout_hit;
    logic [7:0]  wait_cnt;
    logic [1:0]  off_q, size_q;
    logic        uns_q, rd_q;
    logic [31:0] mem_data_q;

    function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] data);
        case (sz)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] sz,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (sz)
            2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    always_comb begin
        access     = mem_read | mem_write;
        misalign_c = ((size == 2'b01) && alu_result[0]) ||
                     (size[1] && (alu_result[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        misalign    = 1'b0;
        start       = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misalign_c) begin
                        misalign = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        start     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            // The access still visible here belongs to the retiring
            // instruction, so DONE never starts a new one.
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A misaligned access must present 0 in the same cycle the pipeline
    // advances past it, hence the gate on top of the register.
    assign mem_data = misalign ? 32'd0 : mem_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_be     <= 4'd0;
            bus_wdata  <= 32'd0;
            bus_err    <= 1'b0;
            mem_data_q <= 32'd0;
            wait_cnt   <= 8'd0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            bus_err <= timeout_hit;
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_write;
                bus_addr  <= {alu_result[31:2], 2'b00};
                bus_be    <= lane_enables(size, alu_result[1:0]);
                bus_wdata <= lane_wdata(size, store_data);
                // Lane selection is kept locally so load extraction does not
                // depend on upstream holding its outputs during the stall.
                off_q     <= alu_result[1:0];
                size_q    <= size;
                uns_q     <= load_unsigned;
                rd_q      <= mem_read;
                wait_cnt  <= 8'd0;
            end
            if (misalign) mem_data_q <= 32'd0;
            if (ack_hit) begin
                bus_req <= 1'b0;
                if (rd_q) mem_data_q <= load_extend(bus_rdata, size_q, off_q, uns_q);
            end else if (timeout_hit) begin
                bus_req    <= 1'b0;
                mem_data_q <= 32'd0;
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] alu_result = 32'd0, store_data = 32'd0;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [31:0] mem_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] mdata;
        logic [7:0]  stalls;
        logic [7:0]  reqs;
        logic        err;
        logic        stable;
        logic        fin;
    } acc_t;

    acc_t sb_q[$];

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .size(size),
        .load_unsigned(load_unsigned), .alu_result(alu_result), .store_data(store_data),
        .stall(stall), .mem_data(mem_data), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic acc_t mk(input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic we,
                                input logic [31:0] mdata, input int stalls,
                                input int reqs, input logic err);
        acc_t e;
        e.addr = addr; e.be = be; e.wdata = wdata; e.we = we; e.mdata = mdata;
        e.stalls = 8'(stalls); e.reqs = 8'(reqs); e.err = err;
        e.stable = 1'b1; e.fin = 1'b1;
        return e;
    endfunction

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; load_unsigned = 1'b0;
        alu_result = 32'd0; store_data = 32'd0; bus_ack = 1'b0;
    endtask

    // Called just after a falling edge. Drives one access, answers the bus
    // after ack_wait extra BUSY cycles (-1 = never) and returns what was seen.
    // Returns just after the falling edge that follows the DONE cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] sd, input int ack_wait,
                              input logic [31:0] rdata, output acc_t obs);
        logic done;
        obs = '0;
        obs.stable = 1'b1;
        done = 1'b0;
        mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns;
        alu_result = addr; store_data = sd; bus_ack = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            bus_rdata = 32'hA5A5_A5A5;
            if (bus_req) begin
                if (obs.reqs == 8'd0) begin
                    obs.addr = bus_addr; obs.be = bus_be; obs.wdata = bus_wdata; obs.we = bus_we;
                end else if (obs.addr !== bus_addr || obs.be !== bus_be ||
                             obs.wdata !== bus_wdata || obs.we !== bus_we) begin
                    obs.stable = 1'b0;
                end
                obs.reqs = obs.reqs + 8'd1;
                if (int'(obs.reqs) - 1 == ack_wait) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata;
                end else begin
                    bus_ack = 1'b0;
                end
            end else begin
                bus_ack = 1'b0;
            end
            if (stall) begin
                obs.stalls = obs.stalls + 8'd1;
            end else begin
                done = 1'b1;
                obs.mdata = mem_data;
                obs.err = bus_err;
                obs.fin = 1'b1;
            end
            @(negedge clk);
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({bus_req, bus_we, bus_err, stall, misalign} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, want 00000", {bus_req, bus_we, bus_err, stall, misalign});
        end
        vectors++;
        if ({bus_addr, bus_be, bus_wdata, mem_data} !== 100'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, want 0", {bus_addr, bus_be, bus_wdata, mem_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
            miscompares++;
            $display("FAIL nonmem_idle: got stall=%b req=%b, want 0 0", stall, bus_req);
        end
        @(negedge clk);
    endtask

    task automatic test_word_load();
        acc_t obs, exp;
        sb_q.push_back(mk(32'h10, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1, 1'b0));
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, obs);
        idle_inputs();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL word_load: got %h, want %h", obs, exp);
        end
    endtask

    task automatic test_byte_loads();
        acc_t obs, exp;
        sb_q.push_back(mk(32'h10, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80, 3, 2, 1'b0));
        run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 32'h80FF_1234, obs);
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL lb: got %h, want %h", obs, exp);
        end
        idle_inputs();
        @(negedge clk);
        sb_q.push_back(mk(32'h10, 4'b1000, 32'h0, 1'b0, 32'h0000_0080, 3, 2, 1'b0));
        run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 32'h80FF_1234, obs);
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL lbu: got %h, want %h", obs, exp);
        end
        idle_inputs();
        @(negedge clk);
        sb_q.push_back(mk(32'h10, 4'b1100, 32'h0, 1'b0, 32'hFFFF_80FF, 2, 1, 1'b0));
        run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 32'h80FF_1234, obs);
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL lh: got %h, want %h", obs, exp);
        end
        idle_inputs();
    endtask

    task automatic test_half_store();
        acc_t obs, exp;
        // A store leaves mem_data at the previous load result.
        sb_q.push_back(mk(32'h20, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'hFFFF_80FF, 5, 4, 1'b0));
        run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 3, 32'h0, obs);
        idle_inputs();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL sh: got %h, want %h", obs, exp);
        end
    endtask

    task automatic test_misalign();
        acc_t obs, exp;
        logic [31:0] addrs [3] = '{32'h6, 32'h1, 32'h2};
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            int reqs_seen;
            @(negedge clk);
            mem_read = 1'b1; size = sizes[i]; alu_result = addrs[i];
            #1;
            vectors++;
            if ({misalign, stall, mem_data} !== {1'b1, 1'b0, 32'd0}) begin
                miscompares++;
                $display("FAIL misalign_%0d: got mis=%b stall=%b data=%h, want 1 0 0",
                         i, misalign, stall, mem_data);
            end
            reqs_seen = 0;
            repeat (3) begin
                @(negedge clk);
                #1;
                if (bus_req !== 1'b0) reqs_seen++;
            end
            vectors++;
            if (reqs_seen != 0) begin
                miscompares++;
                $display("FAIL misalign_req_%0d: got %0d request cycles, want 0", i, reqs_seen);
            end
            idle_inputs();
        end
        @(negedge clk);
        // Byte accesses are never misaligned; mem_data was cleared above.
        sb_q.push_back(mk(32'h0, 4'b1000, 32'h7878_7878, 1'b1, 32'h0, 2, 1, 1'b0));
        run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h3, 32'h1234_5678, 0, 32'h0, obs);
        idle_inputs();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL sb_lane3: got %h, want %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        acc_t obs, exp;
        @(negedge clk);
        sb_q.push_back(mk(32'h40, 4'b1111, 32'h0, 1'b0, 32'h1122_3344, 2, 1, 1'b0));
        sb_q.push_back(mk(32'h44, 4'b1100, 32'h0, 1'b0, 32'h0000_BEEF, 4, 3, 1'b0));
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'h1122_3344, obs);
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL b2b_first: got %h, want %h", obs, exp);
        end
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h46, 32'h0, 2, 32'hBEEF_0000, obs);
        idle_inputs();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL b2b_second: got %h, want %h", obs, exp);
        end
    endtask

    task automatic test_timeout();
        acc_t obs, exp;
        @(negedge clk);
        sb_q.push_back(mk(32'h50, 4'b1111, 32'h0, 1'b0, 32'h0, 5, 4, 1'b1));
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, -1, 32'h0, obs);
        idle_inputs();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL timeout: got %h, want %h", obs, exp);
        end
        #1;
        vectors++;
        if ({bus_err, stall, bus_req} !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout_after: got err/stall/req=%b, want 000", {bus_err, stall, bus_req});
        end
        // A spurious ack while idle must not disturb anything.
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({bus_req, stall, mem_data} !== {1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL idle_ack: got req=%b stall=%b data=%h, want 0 0 0", bus_req, stall, mem_data);
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_read = 1'b1; size = 2'b10; alu_result = 32'h80;
        @(negedge clk);
        #1;
        vectors++;
        if (bus_req !== 1'b1 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_busy: got req=%b stall=%b, want 1 1", bus_req, stall);
        end
        #1;
        rst_n = 1'b0;
        mem_read = 1'b0;
        #1;
        vectors++;
        if ({bus_req, bus_we, bus_err, stall, bus_addr, bus_be, bus_wdata, mem_data} !== 104'd0) begin
            miscompares++;
            $display("FAIL rst_mid_async: got req=%b addr=%h be=%b data=%h stall=%b, want all 0",
                     bus_req, bus_addr, bus_be, mem_data, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({bus_req, stall, bus_err, mem_data} !== {3'b000, 32'd0}) begin
            miscompares++;
            $display("FAIL rst_late_ack: got req=%b stall=%b err=%b data=%h, want 0 0 0 0",
                     bus_req, stall, bus_err, mem_data);
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_load();
        @(negedge clk);
        test_byte_loads();
        @(negedge clk);
        test_half_store();
        test_misalign();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
